// File: rtl/prio_arbiter_pkg.sv
// prio_arbiter_pkg: shared FSM state and arbitration mode types
package prio_arbiter_pkg;
    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;
    typedef enum logic {FIXED = 1'b0, RR = 1'b1} mode_t;
endpackage

// File: rtl/prio_find.sv
// prio_find: highest set bit index of a vector plus an any-bit-set flag
module prio_find #(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          found
);
    always_comb begin
        idx = '0;
        for (int i = 0; i < N; i++) if (vec[i]) idx = IW'(i);
    end
    assign found = |vec;
endmodule

// File: rtl/prio_arbiter.sv
// prio_arbiter: fixed-priority / round-robin arbiter holding one grant until ack or withdrawal
module prio_arbiter
    import prio_arbiter_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic [N-1:0]  req,
    input  logic          mode,
    input  logic          ack,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          grant_valid
);
    localparam int SW = IW + 1;
    state_t state_q, state_d;
    logic [IW-1:0] idx_q, idx_d, ptr_q, ptr_d, fx_idx, rot_idx, rr_idx;
    logic fx_found, rr_found, rr_sel;
    logic [2*N-1:0] req2;
    logic [N-1:0] rot;
    logic [SW-1:0] sh, unrot;
    // Rotating by ptr+1 lands req[ptr] on the top bit, so highest-index search gives RR order
    assign req2   = {req, req};
    assign sh     = SW'(ptr_q) + SW'(1);
    assign rot    = req2[sh +: N];
    assign unrot  = SW'(rot_idx) + sh;
    assign rr_idx = unrot >= SW'(N) ? IW'(unrot - SW'(N)) : IW'(unrot);
    assign rr_sel = mode_t'(mode) == RR;
    prio_find #(.N(N)) u_fx (.vec(req), .idx(fx_idx), .found(fx_found));
    prio_find #(.N(N)) u_rr (.vec(rot), .idx(rot_idx), .found(rr_found));
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (state_q == IDLE) begin
            if (rr_sel ? rr_found : fx_found) begin
                state_d = GRANT;
                idx_d   = rr_sel ? rr_idx : fx_idx;
            end
        end else if (ack || !req[idx_q]) begin
            state_d = IDLE;
            idx_d   = '0;
            ptr_d   = idx_q == '0 ? IW'(N - 1) : idx_q - IW'(1);
        end
    end
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= IW'(N - 1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end
    assign grant_valid = state_q == GRANT;
    assign grant_idx   = idx_q;
    assign grant       = grant_valid ? N'(1) << idx_q : '0;
endmodule

// File: tb/tb_prio_arbiter.sv
// tb_prio_arbiter: directed and randomized checks of prio_arbiter against a behavioural model
module tb_prio_arbiter;
    logic clk = 0, rstN = 0, mode = 0, ack = 0;
    logic [7:0] req = 0, grant;
    logic [2:0] grant_idx;
    logic grant_valid;
    logic [3:0] req4 = 0, grant4;
    logic [1:0] grant_idx4;
    logic grant_valid4;
    int errors = 0, checks = 0;
    bit m_valid = 0;
    int m_idx = 0, m_ptr = 7;

    always #5 clk = ~clk;

    prio_arbiter #(.N(8)) dut (.clk(clk), .rstN(rstN), .req(req), .mode(mode), .ack(ack),
        .grant(grant), .grant_idx(grant_idx), .grant_valid(grant_valid));
    prio_arbiter #(.N(4)) dut4 (.clk(clk), .rstN(rstN), .req(req4), .mode(1'b0), .ack(1'b0),
        .grant(grant4), .grant_idx(grant_idx4), .grant_valid(grant_valid4));

    function automatic int fixed_win(input logic [7:0] r);
        for (int i = 7; i >= 0; i--) if (r[i]) return i;
        return 0;
    endfunction

    function automatic int rr_win(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) if (r[(p - k + 8) % 8]) return (p - k + 8) % 8;
        return 0;
    endfunction

    function automatic logic [7:0] m_grant();
        return m_valid ? 8'(1 << m_idx) : 8'h00;
    endfunction

    task automatic step(input logic [7:0] r, input logic m, input logic a);
        req = r; mode = m; ack = a;
        @(posedge clk);
        if (!m_valid) begin
            if (r != 0) begin
                m_valid = 1;
                m_idx = m ? rr_win(r, m_ptr) : fixed_win(r);
            end
        end else if (a || !r[m_idx]) begin
            m_valid = 0;
            m_ptr = (m_idx + 7) % 8;
            m_idx = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        req = 0; req4 = 0; ack = 0; mode = 0;
        rstN = 0;
        m_valid = 0; m_idx = 0; m_ptr = 7;
        @(posedge clk);
        #1 rstN = 1;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (grant !== 8'h00) begin errors++; $display("FAIL reset_grant: got %h want 00", grant); end
        checks++; if (grant_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", grant_idx); end
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", grant_valid); end
        @(posedge clk);
        #1 rstN = 1;
    endtask

    task automatic test_fixed();
        step(8'h0C, 0, 0);
        checks++; if (grant !== 8'h08) begin errors++; $display("FAIL fixed_grant: got %h want 08", grant); end
        checks++; if (grant_idx !== 3'd3) begin errors++; $display("FAIL fixed_idx: got %0d want 3", grant_idx); end
        for (int k = 0; k < 2; k++) begin
            step(8'h0C, 0, 0);
            checks++; if (grant !== 8'h08 || grant_valid !== 1'b1) begin
                errors++; $display("FAIL fixed_hold: got %h/%b want 08/1", grant, grant_valid);
            end
        end
        step(8'h0C, 0, 1);
        checks++; if (grant !== 8'h00 || grant_valid !== 1'b0 || grant_idx !== 3'd0) begin
            errors++; $display("FAIL fixed_release: got %h/%b/%0d want 00/0/0", grant, grant_valid, grant_idx);
        end
        step(8'h00, 0, 0);
    endtask

    task automatic test_rr_sweep();
        int exp_seq[9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 1, 1);
            checks++; if (grant_valid !== 1'b1 || grant_idx !== 3'(exp_seq[k])) begin
                errors++; $display("FAIL rr_seq[%0d]: got %b/%0d want 1/%0d", k, grant_valid, grant_idx, exp_seq[k]);
            end
            step(8'hFF, 1, 1);
            checks++; if (grant_valid !== 1'b0) begin
                errors++; $display("FAIL rr_gap[%0d]: got valid %b want 0", k, grant_valid);
            end
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        step(8'h20, 0, 0);
        checks++; if (grant_idx !== 3'd5 || grant_valid !== 1'b1) begin
            errors++; $display("FAIL wd_grant: got %0d/%b want 5/1", grant_idx, grant_valid);
        end
        step(8'h00, 0, 0);
        checks++; if (grant_valid !== 1'b0 || grant !== 8'h00) begin
            errors++; $display("FAIL wd_release: got %b/%h want 0/00", grant_valid, grant);
        end
        step(8'hFF, 1, 0);
        checks++; if (grant_idx !== 3'd4) begin
            errors++; $display("FAIL wd_ptr: got next rr idx %0d want 4", grant_idx);
        end
        step(8'h00, 1, 1);
    endtask

    task automatic test_async_reset();
        do_reset();
        step(8'h04, 0, 0);
        checks++; if (grant_idx !== 3'd2 || grant_valid !== 1'b1) begin
            errors++; $display("FAIL ar_grant: got %0d/%b want 2/1", grant_idx, grant_valid);
        end
        #3 rstN = 0;
        #1;
        checks++; if (grant !== 8'h00 || grant_idx !== 3'd0 || grant_valid !== 1'b0) begin
            errors++; $display("FAIL ar_async: got %h/%0d/%b want 00/0/0", grant, grant_idx, grant_valid);
        end
        m_valid = 0; m_idx = 0; m_ptr = 7;
        #1 rstN = 1;
        step(8'h81, 1, 0);
        checks++; if (grant_idx !== 3'd7 || grant !== 8'h80) begin
            errors++; $display("FAIL ar_rr: got %0d/%h want 7/80", grant_idx, grant);
        end
        step(8'h00, 1, 1);
    endtask

    task automatic test_idle_ack_mode();
        for (int k = 0; k < 5; k++) begin
            step(8'h00, 0, 1);
            checks++; if (grant_valid !== 1'b0) begin
                errors++; $display("FAIL idle_ack[%0d]: got valid %b want 0", k, grant_valid);
            end
        end
        step(8'hFF, 1, 0);
        checks++; if (grant_idx !== 3'd6 || grant_idx !== 3'(m_idx)) begin
            errors++; $display("FAIL idle_ptr: got %0d want 6 (model %0d)", grant_idx, m_idx);
        end
        step(8'hFF, 1, 1);
        step(8'h11, 0, 0);
        checks++; if (grant_idx !== 3'd4) begin
            errors++; $display("FAIL mode_grant: got %0d want 4", grant_idx);
        end
        for (int k = 0; k < 4; k++) begin
            step(8'h11, k[0] ? 1'b0 : 1'b1, 0);
            checks++; if (grant !== 8'h10 || grant_valid !== 1'b1) begin
                errors++; $display("FAIL mode_toggle[%0d]: got %h/%b want 10/1", k, grant, grant_valid);
            end
        end
        step(8'h00, 0, 1);
    endtask

    task automatic test_random();
        logic [7:0] r;
        do_reset();
        for (int k = 0; k < 500; k++) begin
            r = $urandom_range(0, 4) == 0 ? 8'h00 : ($urandom_range(0, 1) ? 8'($urandom) : 8'($urandom) & 8'($urandom));
            step(r, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            checks++; if (grant_valid !== m_valid) begin
                errors++; $display("FAIL rand_valid[%0d]: got %b want %b", k, grant_valid, m_valid);
            end
            checks++; if (grant_idx !== 3'(m_idx)) begin
                errors++; $display("FAIL rand_idx[%0d]: got %0d want %0d", k, grant_idx, m_idx);
            end
            checks++; if (grant !== m_grant()) begin
                errors++; $display("FAIL rand_grant[%0d]: got %h want %h", k, grant, m_grant());
            end
        end
    endtask

    task automatic test_n4();
        do_reset();
        req4 = 4'b0101;
        @(posedge clk);
        #1;
        checks++; if (grant_idx4 !== 2'd2) begin errors++; $display("FAIL n4_idx: got %0d want 2", grant_idx4); end
        checks++; if (grant4 !== 4'b0100) begin errors++; $display("FAIL n4_grant: got %b want 0100", grant4); end
        checks++; if (grant_valid4 !== 1'b1) begin errors++; $display("FAIL n4_valid: got %b want 1", grant_valid4); end
        req4 = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_sweep();
        test_withdraw();
        test_async_reset();
        test_idle_ack_mode();
        test_random();
        test_n4();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/prio_arbiter.md
PRIO_ARBITER -- requirements
Module: prio_arbiter

Interface
REQ-001 SHALL have parameter N, default 8: number of requesters, legal range 2..32.
REQ-002 SHALL have parameter IW, default $clog2(N): grant index width, derived from N and not overridden.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rstN, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req, input, N bits: one request bit per requester.
REQ-006 SHALL have port mode, input, 1 bit: 0 = fixed priority (highest index wins); 1 = round-robin.
REQ-007 SHALL have port ack, input, 1 bit: consumer completion of the current grant.
REQ-008 SHALL have port grant, output, N bits: one-hot grant, or all zeros.
REQ-009 SHALL have port grant_idx, output, IW bits: index of the granted requester.
REQ-010 SHALL have port grant_valid, output, 1 bit: high while a grant is held.

Function
REQ-011 SHALL implement a two-state FSM with states IDLE and GRANT.
REQ-012 IDLE: when req is non-zero at a clock edge, SHALL register the winner, assert grant_valid and go to GRANT; outputs appear one cycle after req is sampled.
REQ-013 IDLE: when req is zero, SHALL stay in IDLE with all outputs zero.
REQ-014 In fixed mode (mode=0), the winner SHALL be the highest set index of req.
REQ-015 In round-robin mode (mode=1), priority SHALL descend from the pointer ptr through ptr-1, ..., 0, N-1, ..., wrapping modulo N; the first set bit wins.
REQ-016 mode SHALL be sampled only at the IDLE arbitration edge; a change while in GRANT has no effect until the next arbitration.
REQ-017 GRANT: grant, grant_idx and grant_valid SHALL hold stable while ack=0 and req[grant_idx]=1.
REQ-018 GRANT: when ack=1 or req[grant_idx]=0, SHALL clear all outputs at that edge and return to IDLE; ack and withdrawal together count as one release.
REQ-019 On every release, ptr SHALL update to (grant_idx-1) mod N, so that grant_idx-1 gets top priority and index 0 wraps to N-1; ptr SHALL update in both modes.
REQ-020 At least one IDLE cycle SHALL separate consecutive grants, giving a maximum rate of one grant per 2 cycles.
REQ-021 ack SHALL be ignored while in IDLE.
REQ-022 Requests from non-granted requesters arriving during GRANT SHALL be ignored until the next arbitration; no preemption.
REQ-023 grant SHALL always equal one-hot(grant_idx) when grant_valid=1, and all zeros otherwise.

Reset
REQ-024 rstN low SHALL asynchronously force state to IDLE, grant to 0, grant_idx to 0, grant_valid to 0 and ptr to N-1, including in the middle of a grant.
REQ-025 After rstN deasserts, the first arbitration SHALL occur on the first rising edge at which req is non-zero.

Structure
REQ-026 The package prio_arbiter_pkg SHALL hold the state enum typedef (IDLE, GRANT) and the mode enum typedef (FIXED=0, RR=1).
REQ-027 N-dependent widths SHALL remain module parameters and not be placed in the package.
REQ-028 There SHALL be one combinational sub-module, prio_find, parameterised by N: input an N-bit vector; outputs the highest set index and a found flag.
REQ-029 Round-robin SHALL be implemented as: rotate req by ptr, apply prio_find, then un-rotate the index.

Verification (N=8 unless stated)
REQ-030 Fixed mode, req=8'b0000_1100, ack asserted 3 cycles later -> grant=8'b0000_1000 and grant_idx=3 one cycle after req, held until ack, then zero on the next cycle.
REQ-031 RR mode, req=8'hFF held, ack on every grant cycle -> grant_idx sequence 7,6,5,4,3,2,1,0,7, with one IDLE cycle between each.
REQ-032 Fixed mode, req[5] granted and then req[5] dropped with ack=0 -> grant_valid=0 on the next cycle and ptr=4.
REQ-033 rstN pulsed low while grant_valid=1 with grant_idx=2 -> outputs zero immediately without waiting for clk; then RR mode with req=8'h81 -> grant_idx=7.
REQ-034 ack=1 with req=0 in IDLE for 5 cycles -> grant_valid stays 0 and ptr is unchanged; mode toggled during GRANT -> grant unchanged.
REQ-035 N=4 instance, fixed mode, req=4'b0101 -> grant_idx=2 and grant=4'b0100.
